// File: rtl/mem_responder_pkg.sv
// Shared types, constants and the byte-lane merge helper for mem_responder.
package mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // Wide enough for LATENCY up to 15 plus 3 random extra cycles.
  localparam int CNT_W = 5;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_lfsr16.sv
// 16-bit Fibonacci LFSR, advanced on request; used for random response latency.
module lfsr16
  import mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with fixed latency and byte-enabled writes.
// Define MEM_RESPONDER_RANDOM_LATENCY_EN to add 0..3 LFSR-chosen extra wait cycles.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata
);

  mem_resp_state_t state, state_next;
  logic [CNT_W-1:0]     count, count_next;
  logic [CNT_W-1:0]     lat_load;
  logic                 accept;
  logic                 op_write;
  logic [ADDR_BITS-1:0] idx;
  logic [3:0]           be_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [31:0]          mem [2**ADDR_BITS];
  logic                 unused_addr;

  assign unused_addr = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};
  assign accept      = (state == IDLE) && (mem_read || mem_write);

`ifdef MEM_RESPONDER_RANDOM_LATENCY_EN
  logic [15:0] lfsr_state;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (accept),
    .state   (lfsr_state)
  );

  assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr_state[1:0]);
`else
  assign lat_load = CNT_W'(LATENCY);
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (accept) begin
          count_next = lat_load - CNT_W'(1);
          state_next = (lat_load == CNT_W'(1)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_next = count - CNT_W'(1);
        if (count == CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      // A simultaneous read+write is latched as a write.
      if (accept) begin
        op_write <= mem_write;
        idx      <= mem_address[ADDR_BITS+1:2];
        be_q     <= mem_byte_enable;
        wdata_q  <= mem_wdata;
      end
      if (state == RESP && !op_write) rdata_q <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_write) begin
      mem[idx] <= byte_merge(mem[idx], wdata_q, be_q);
    end
  end

  // Reset in the RESP cycle suppresses the pulse as well as the write.
  assign mem_resp  = (state == RESP) && !rst;
  assign mem_rdata = (mem_resp && !op_write) ? mem[idx] : rdata_q;

endmodule
